// File: rtl/pressure_sample_tx.sv
// Pressure sample serial transmitter: start, data LSB first, optional parity, stop.
// Ports: clk, reset (sync, active high), tx_data/tx_valid/tx_ready handshake,
//        tx serial line (idle high), busy, frame_done (1-cycle pulse after stop).
module pressure_sample_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;
  logic                    tc;

  assign tc = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (tx_valid) begin
          state_d = START;
          shift_d = tx_data;
          // parity fixed at accept so later tx_data changes cannot leak in
          par_d   = (^tx_data) ^ (PARITY_ODD != 0);
        end
      end
      START: begin
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        if (tc) state_d = DATA;
      end
      DATA: begin
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        if (tc) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        if (tc) state_d = STOP;
      end
      STOP: begin
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        if (tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // line level is a function of the state being entered, so tx stays registered
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = ~tx_ready;
  assign tx         = tx_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pressure_sample_tx.sv
// Directed bench for pressure_sample_tx: 8N1, 8E1 and 8O1 instances at 4 clks/bit.
// Expected line waveforms are built from hand-written frame bit patterns.
module tb_pressure_sample_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] vld = 3'b000;
  logic [2:0] tx_o, rdy_o, busy_o, done_o;

  int n_checks = 0;
  int n_fail = 0;
  int dc0 = 0;
  int dc1 = 0;
  int dc2 = 0;

  logic [63:0] v, v1, v2;
  int          r;

  always #5 clk = ~clk;

  pressure_sample_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)
  ) u_8n1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(vld[0]),
    .tx_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]),
    .frame_done(done_o[0])
  );

  pressure_sample_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_8e1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(vld[1]),
    .tx_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]),
    .frame_done(done_o[1])
  );

  pressure_sample_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)
  ) u_8o1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(vld[2]),
    .tx_ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]),
    .frame_done(done_o[2])
  );

  always @(negedge clk) begin
    if (done_o[0]) dc0 <= dc0 + 1;
    if (done_o[1]) dc1 <= dc1 + 1;
    if (done_o[2]) dc2 <= dc2 + 1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int d, input int n,
                         output logic [63:0] cv, output int rdy_hi);
    cv = '0;
    rdy_hi = 0;
    for (int k = 0; k < n; k++) begin
      cv[k] = tx_o[d];
      if (rdy_o[d]) rdy_hi++;
      tick();
    end
  endtask

  function automatic logic [63:0] expand(input logic [15:0] bits, input int n);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < n * CPB; i++) e[i] = bits[i / CPB];
    return e;
  endfunction

  function automatic logic [63:0] st0;
    return 64'({tx_o[0], rdy_o[0], busy_o[0], done_o[0]});
  endfunction

  initial begin
    // 1: reset held three cycles, then released
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold", st0(), 64'(4'b1100));
    end
    reset = 1'b0;
    tick();
    check("rst_rel", st0(), 64'(4'b1100));

    // 2: 0xA5 8N1, single valid pulse
    tx_data = 8'hA5;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    capture(0, 40, v, r);
    check("a5_8n1_bits", v, expand(16'({1'b1, 8'hA5, 1'b0}), 10));
    check("a5_8n1_rdy_low", 64'(r), 64'(0));
    check("a5_8n1_end", st0(), 64'(4'b1101));
    tick();
    check("a5_8n1_done_off", 64'(done_o[0]), 64'(0));
    check("a5_8n1_ndone", 64'(dc0), 64'(1));

    // 3: 0xA5 even parity (bit 0) and odd parity (bit 1), 44 cycles
    vld[1] = 1'b1;
    tick();
    vld[1] = 1'b0;
    capture(1, 44, v, r);
    check("a5_8e1_bits", v, expand(16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11));
    check("a5_8e1_rdy_low", 64'(r), 64'(0));
    check("a5_8e1_done", 64'({done_o[1], rdy_o[1]}), 64'(2'b11));
    vld[2] = 1'b1;
    tick();
    vld[2] = 1'b0;
    capture(2, 44, v, r);
    check("a5_8o1_bits", v, expand(16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11));
    check("a5_8o1_rdy_low", 64'(r), 64'(0));
    check("a5_8o1_done", 64'({done_o[2], rdy_o[2]}), 64'(2'b11));
    tick();
    check("par_ndone", 64'({dc1[7:0], dc2[7:0]}), 64'(16'h0101));

    // 4: back-to-back 0x3C then 0xFF, data changed mid-frame
    tx_data = 8'h3C;
    vld[0] = 1'b1;
    tick();
    capture(0, 20, v1, r);
    tx_data = 8'hFF;
    capture(0, 20, v2, r);
    v = v1 | (v2 << 20);
    check("b2b_3c_bits", v, expand(16'({1'b1, 8'h3C, 1'b0}), 10));
    check("b2b_gap", st0(), 64'(4'b1101));
    tick();
    vld[0] = 1'b0;
    check("b2b_restart", 64'({tx_o[0], busy_o[0]}), 64'(2'b01));
    capture(0, 40, v, r);
    check("b2b_ff_bits", v, expand(16'({1'b1, 8'hFF, 1'b0}), 10));
    check("b2b_ff_end", st0(), 64'(4'b1101));
    tick();
    check("b2b_ndone", 64'(dc0), 64'(3));

    // 5: reset during data bit 3 of 0x00, then 0x81
    tx_data = 8'h00;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    repeat (17) tick();
    check("abort_pre", 64'({tx_o[0], busy_o[0]}), 64'(2'b01));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_post", st0(), 64'(4'b1100));
    tick();
    check("abort_idle", st0(), 64'(4'b1100));
    check("abort_ndone", 64'(dc0), 64'(3));
    tx_data = 8'h81;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    capture(0, 40, v, r);
    check("x81_bits", v, expand(16'({1'b1, 8'h81, 1'b0}), 10));
    check("x81_end", st0(), 64'(4'b1101));

    // 6: valid pulses while busy are dropped
    tick();
    tx_data = 8'h55;
    vld[0] = 1'b1;
    tick();
    v = '0;
    for (int k = 0; k < 40; k++) begin
      v[k] = tx_o[0];
      vld[0] = (k == 10) || (k == 30);
      tx_data = (k == 10) ? 8'h0F : 8'h55;
      tick();
    end
    vld[0] = 1'b0;
    check("busy_bits", v, expand(16'({1'b1, 8'h55, 1'b0}), 10));
    check("busy_end", st0(), 64'(4'b1101));
    r = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (busy_o[0]) r++;
    end
    check("busy_no_extra", 64'(r), 64'(0));
    check("busy_ndone", 64'(dc0), 64'(5));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
